// File: rtl/rotary_position_pkg.sv
// Shared constants for the rotary encoder position tracker.
// Holds direction encodings (shared with the encoder decoder) and
// the bound-handling mode selectors.
package rotary_position_pkg;

    // Step direction as carried on i_cnt_cw
    localparam logic CW  = 1'b1;
    localparam logic CCW = 1'b0;

    // Bound handling mode, selected by the WRAP parameter
    localparam int unsigned MODE_SAT  = 0;
    localparam int unsigned MODE_WRAP = 1;

endpackage : rotary_position_pkg

// File: rtl/rotary_position_if.sv
// Step/load/event bundle between the encoder decoder, the position
// tracker and the position consumer.
//   i_cnt, i_cnt_cw        : step strobe and direction
//   i_load, i_load_value   : synchronous position load
//   i_ready                : consumer accepts the change event
//   o_pos, o_valid, o_limit: position, change-pending flag, bound pulse
interface rotary_position_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             i_cnt;
    logic             i_cnt_cw;
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic             i_ready;
    logic [WIDTH-1:0] o_pos;
    logic             o_valid;
    logic             o_limit;

    modport master (
        output i_cnt, i_cnt_cw, i_load, i_load_value, i_ready,
        input  o_pos, o_valid, o_limit
    );

    modport slave (
        input  i_cnt, i_cnt_cw, i_load, i_load_value, i_ready,
        output o_pos, o_valid, o_limit
    );

endinterface : rotary_position_if

// File: rtl/rotary_accel.sv
// Step-size selection for the rotary position tracker.
// Counts cycles since the last step strobe (saturating at FAST_GAP) and
// remembers the last direction; a quick repeat in the same direction
// selects ACCEL_STEP, anything else selects 1.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_cnt, i_cnt_cw: step strobe and direction
//   o_step_c       : step size for the strobe presented this cycle
module rotary_accel
    import rotary_position_pkg::*;
#(
    parameter int unsigned FAST_GAP   = 8,
    parameter int unsigned ACCEL_STEP = 3,
    parameter int unsigned SW         = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cnt,
    input  logic          i_cnt_cw,
    output logic [SW-1:0] o_step_c
);

    localparam int unsigned GW = (FAST_GAP > 0) ? $clog2(FAST_GAP + 1) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(FAST_GAP);

    logic [GW-1:0] r_gap;
    logic          r_dir;
    logic          w_fast;

    // Gap counter and last direction; every strobe counts, even a discarded one
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap <= GAP_MAX;
            r_dir <= CW;
        end else if (i_cnt) begin
            r_gap <= '0;
            r_dir <= i_cnt_cw;
        end else if (r_gap < GAP_MAX) begin
            r_gap <= r_gap + GW'(1);
        end
    end

    // A reversal never accelerates
    assign w_fast   = (r_gap < GAP_MAX) && (i_cnt_cw == r_dir);
    assign o_step_c = w_fast ? SW'(ACCEL_STEP) : SW'(1);

endmodule : rotary_accel

// File: rtl/rotary_position.sv
// Rotary encoder position register with acceleration, saturate or wrap
// at the bounds, priority load, and a coalescing change event.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : step/load inputs, i_ready, o_pos/o_valid/o_limit
module rotary_position
    import rotary_position_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned POS_MIN    = 0,
    parameter int unsigned POS_MAX    = 255,
    parameter int unsigned WRAP       = 0,
    parameter int unsigned FAST_GAP   = 8,
    parameter int unsigned ACCEL_STEP = 3,
    parameter int unsigned RESET_POS  = POS_MIN
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    rotary_position_if.slave bus
);

    // One extra bit so pos + step never overflows
    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MIN_X  = XW'(POS_MIN);
    localparam logic [XW-1:0] MAX_X  = XW'(POS_MAX);
    localparam logic [XW-1:0] SPAN_X = XW'(POS_MAX - POS_MIN + 1);

    logic [WIDTH-1:0] r_pos;
    logic             r_valid;
    logic             r_limit;

    logic [XW-1:0]    w_step;
    logic [XW-1:0]    w_pos_x;
    logic [XW-1:0]    w_off;
    logic [XW-1:0]    w_res;
    logic             w_over;
    logic [XW-1:0]    w_load_x;
    logic [WIDTH-1:0] w_next;
    logic             w_limit;
    logic             w_changed;

    rotary_accel #(
        .FAST_GAP  (FAST_GAP),
        .ACCEL_STEP(ACCEL_STEP),
        .SW        (XW)
    ) u_accel (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_cnt   (bus.i_cnt),
        .i_cnt_cw(bus.i_cnt_cw),
        .o_step_c(w_step)
    );

    assign w_pos_x = {1'b0, r_pos};
    assign w_off   = w_pos_x - MIN_X;

    // Stepped position; w_over flags a clamp (saturate mode only)
    always_comb begin
        w_res  = w_pos_x;
        w_over = 1'b0;
        if (bus.i_cnt_cw == CW) begin
            if (WRAP == MODE_WRAP) begin
                if ((w_off + w_step) >= SPAN_X) begin
                    w_res = MIN_X + w_off + w_step - SPAN_X;
                end else begin
                    w_res = MIN_X + w_off + w_step;
                end
            end else if ((w_pos_x + w_step) > MAX_X) begin
                w_res  = MAX_X;
                w_over = 1'b1;
            end else begin
                w_res = w_pos_x + w_step;
            end
        end else begin
            if (w_off >= w_step) begin
                w_res = w_pos_x - w_step;
            end else if (WRAP == MODE_WRAP) begin
                w_res = w_pos_x + SPAN_X - w_step;
            end else begin
                w_res  = MIN_X;
                w_over = 1'b1;
            end
        end
    end

    // Load value clamped into range regardless of mode
    always_comb begin
        w_load_x = {1'b0, bus.i_load_value};
        if (w_load_x > MAX_X) begin
            w_load_x = MAX_X;
        end else if (w_load_x < MIN_X) begin
            w_load_x = MIN_X;
        end
    end

    // Load wins over a same-cycle step
    always_comb begin
        w_next  = r_pos;
        w_limit = 1'b0;
        if (bus.i_load) begin
            w_next = WIDTH'(w_load_x);
        end else if (bus.i_cnt) begin
            w_next  = WIDTH'(w_res);
            w_limit = w_over;
        end
    end

    assign w_changed = (w_next != r_pos);

    // Event stays pending until accepted; a fresh change re-arms it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos   <= WIDTH'(RESET_POS);
            r_valid <= 1'b0;
            r_limit <= 1'b0;
        end else begin
            r_pos   <= w_next;
            r_limit <= w_limit;
            r_valid <= w_changed | (r_valid & ~bus.i_ready);
        end
    end

    assign bus.o_pos   = r_pos;
    assign bus.o_valid = r_valid;
    assign bus.o_limit = r_limit;

endmodule : rotary_position

// File: tb/tb_rotary_position.sv
// Directed bench: a saturating and a wrapping instance share stimulus.
module tb_rotary_position;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cnt = 1'b0;
    logic         cnt_cw = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotary_position_if #(.WIDTH(W)) if_s ();
    rotary_position_if #(.WIDTH(W)) if_w ();

    assign if_s.i_cnt = cnt;
    assign if_s.i_cnt_cw = cnt_cw;
    assign if_s.i_load = load;
    assign if_s.i_load_value = load_value;
    assign if_s.i_ready = ready;
    assign if_w.i_cnt = cnt;
    assign if_w.i_cnt_cw = cnt_cw;
    assign if_w.i_load = load;
    assign if_w.i_load_value = load_value;
    assign if_w.i_ready = ready;

    rotary_position #(
        .WIDTH(W), .POS_MIN(0), .POS_MAX(9), .WRAP(0),
        .FAST_GAP(8), .ACCEL_STEP(3), .RESET_POS(0)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_s)
    );

    rotary_position #(
        .WIDTH(W), .POS_MIN(0), .POS_MAX(9), .WRAP(1),
        .FAST_GAP(8), .ACCEL_STEP(3), .RESET_POS(0)
    ) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_w)
    );

    // Stimulus helpers: entered at a negedge, return at a negedge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input logic cw);
        cnt = 1'b1;
        cnt_cw = cw;
        @(negedge clk);
        cnt = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic with_cnt, input logic cw);
        load = 1'b1;
        load_value = v;
        cnt = with_cnt;
        cnt_cw = cw;
        @(negedge clk);
        load = 1'b0;
        cnt = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (if_s.o_pos !== 4'd0 || if_s.o_valid !== 1'b0 || if_s.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL reset_sat pos=%0d valid=%b limit=%b exp 0/0/0", if_s.o_pos, if_s.o_valid, if_s.o_limit);
        end
        checks++;
        if (if_w.o_pos !== 4'd0 || if_w.o_valid !== 1'b0 || if_w.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap pos=%0d valid=%b limit=%b exp 0/0/0", if_w.o_pos, if_w.o_valid, if_w.o_limit);
        end
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_slow_cw;
        for (int k = 1; k <= 3; k++) begin
            step(1'b1);
            checks++;
            if (if_s.o_pos !== W'(k) || if_s.o_valid !== 1'b1 || if_s.o_limit !== 1'b0) begin
                errors++;
                $display("FAIL slow_cw_%0d pos=%0d valid=%b limit=%b exp %0d/1/0", k, if_s.o_pos, if_s.o_valid, if_s.o_limit, k);
            end
            checks++;
            if (if_w.o_pos !== W'(k)) begin
                errors++;
                $display("FAIL slow_cw_wrap_%0d pos=%0d exp %0d", k, if_w.o_pos, k);
            end
            idle(1);
            checks++;
            if (if_s.o_valid !== 1'b0 || if_s.o_limit !== 1'b0) begin
                errors++;
                $display("FAIL slow_cw_clear_%0d valid=%b limit=%b exp 0/0", k, if_s.o_valid, if_s.o_limit);
            end
            idle(18);
        end
    endtask

    task automatic test_accel;
        logic [W-1:0] exp_pos [4];
        logic         dirs [4];
        exp_pos[0] = 4'd1; exp_pos[1] = 4'd4; exp_pos[2] = 4'd7; exp_pos[3] = 4'd6;
        dirs[0] = 1'b1; dirs[1] = 1'b1; dirs[2] = 1'b1; dirs[3] = 1'b0;
        test_reset();
        for (int k = 0; k < 4; k++) begin
            step(dirs[k]);
            checks++;
            if (if_s.o_pos !== exp_pos[k] || if_w.o_pos !== exp_pos[k]) begin
                errors++;
                $display("FAIL accel_%0d sat=%0d wrap=%0d exp %0d", k, if_s.o_pos, if_w.o_pos, exp_pos[k]);
            end
            idle(3);
        end
    endtask

    task automatic test_bounds;
        do_load(4'd9, 1'b0, 1'b0);
        idle(19);
        step(1'b1);
        checks++;
        if (if_s.o_pos !== 4'd9 || if_s.o_limit !== 1'b1 || if_s.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold pos=%0d limit=%b valid=%b exp 9/1/0", if_s.o_pos, if_s.o_limit, if_s.o_valid);
        end
        checks++;
        if (if_w.o_pos !== 4'd0 || if_w.o_limit !== 1'b0 || if_w.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_up pos=%0d limit=%b valid=%b exp 0/0/1", if_w.o_pos, if_w.o_limit, if_w.o_valid);
        end
        idle(1);
        checks++;
        if (if_s.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL sat_limit_pulse limit=%b exp 0", if_s.o_limit);
        end
        do_load(4'd7, 1'b0, 1'b0);
        step(1'b1);
        checks++;
        if (if_s.o_pos !== 4'd9 || if_s.o_limit !== 1'b1 || if_s.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp pos=%0d limit=%b valid=%b exp 9/1/1", if_s.o_pos, if_s.o_limit, if_s.o_valid);
        end
        checks++;
        if (if_w.o_pos !== 4'd0 || if_w.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL wrap_accel7 pos=%0d limit=%b exp 0/0", if_w.o_pos, if_w.o_limit);
        end
    endtask

    task automatic test_wrap;
        do_load(4'd9, 1'b0, 1'b0);
        idle(19);
        step(1'b1);
        idle(19);
        step(1'b0);
        checks++;
        if (if_w.o_pos !== 4'd9 || if_w.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL wrap_down pos=%0d limit=%b exp 9/0", if_w.o_pos, if_w.o_limit);
        end
        checks++;
        if (if_s.o_pos !== 4'd8) begin
            errors++;
            $display("FAIL sat_down pos=%0d exp 8", if_s.o_pos);
        end
        // Load with a same-cycle CW strobe: strobe discarded but arms acceleration
        do_load(4'd8, 1'b1, 1'b1);
        checks++;
        if (if_w.o_pos !== 4'd8 || if_s.o_pos !== 4'd8) begin
            errors++;
            $display("FAIL load_prio8 sat=%0d wrap=%0d exp 8", if_s.o_pos, if_w.o_pos);
        end
        step(1'b1);
        checks++;
        if (if_w.o_pos !== 4'd1 || if_w.o_limit !== 1'b0) begin
            errors++;
            $display("FAIL wrap_accel8 pos=%0d limit=%b exp 1/0", if_w.o_pos, if_w.o_limit);
        end
        checks++;
        if (if_s.o_pos !== 4'd9 || if_s.o_limit !== 1'b1) begin
            errors++;
            $display("FAIL sat_accel8 pos=%0d limit=%b exp 9/1", if_s.o_pos, if_s.o_limit);
        end
    endtask

    task automatic test_ready;
        do_load(4'd2, 1'b0, 1'b0);
        idle(2);
        checks++;
        if (if_s.o_valid !== 1'b0 || if_s.o_pos !== 4'd2) begin
            errors++;
            $display("FAIL ready_pre valid=%b pos=%0d exp 0/2", if_s.o_valid, if_s.o_pos);
        end
        ready = 1'b0;
        idle(19);
        step(1'b1);
        idle(19);
        step(1'b1);
        idle(2);
        checks++;
        if (if_s.o_valid !== 1'b1 || if_s.o_pos !== 4'd4) begin
            errors++;
            $display("FAIL ready_hold valid=%b pos=%0d exp 1/4", if_s.o_valid, if_s.o_pos);
        end
        ready = 1'b1;
        step(1'b1);
        checks++;
        if (if_s.o_valid !== 1'b1 || if_s.o_pos !== 4'd7) begin
            errors++;
            $display("FAIL ready_same_edge valid=%b pos=%0d exp 1/7", if_s.o_valid, if_s.o_pos);
        end
        idle(1);
        checks++;
        if (if_s.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_clear valid=%b exp 0", if_s.o_valid);
        end
        do_load(4'd5, 1'b1, 1'b1);
        checks++;
        if (if_s.o_pos !== 4'd5 || if_w.o_pos !== 4'd5) begin
            errors++;
            $display("FAIL load_prio5 sat=%0d wrap=%0d exp 5", if_s.o_pos, if_w.o_pos);
        end
        do_load(4'd12, 1'b0, 1'b0);
        checks++;
        if (if_s.o_pos !== 4'd9 || if_w.o_pos !== 4'd9) begin
            errors++;
            $display("FAIL load_clamp sat=%0d wrap=%0d exp 9", if_s.o_pos, if_w.o_pos);
        end
        idle(2);
        do_load(4'd9, 1'b0, 1'b0);
        checks++;
        if (if_s.o_valid !== 1'b0 || if_w.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_same sat_valid=%b wrap_valid=%b exp 0", if_s.o_valid, if_w.o_valid);
        end
    endtask

    task automatic test_reset_mid;
        idle(19);
        ready = 1'b0;
        do_load(4'd3, 1'b0, 1'b0);
        step(1'b1);
        step(1'b1);
        checks++;
        if (if_s.o_pos !== 4'd7 || if_s.o_valid !== 1'b1 || if_w.o_pos !== 4'd7) begin
            errors++;
            $display("FAIL burst_pre sat=%0d valid=%b wrap=%0d exp 7/1/7", if_s.o_pos, if_s.o_valid, if_w.o_pos);
        end
        cnt = 1'b1;
        cnt_cw = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_s.o_pos !== 4'd0 || if_s.o_valid !== 1'b0 || if_w.o_pos !== 4'd0 || if_w.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid sat=%0d/%b wrap=%0d/%b exp 0/0", if_s.o_pos, if_s.o_valid, if_w.o_pos, if_w.o_valid);
        end
        cnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        step(1'b1);
        checks++;
        if (if_s.o_pos !== 4'd1 || if_w.o_pos !== 4'd1 || if_s.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_step sat=%0d wrap=%0d valid=%b exp 1/1/1", if_s.o_pos, if_w.o_pos, if_s.o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_slow_cw();
        test_accel();
        test_bounds();
        test_wrap();
        test_ready();
        test_reset_mid();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule : tb_rotary_position

// File: doc/rotary_position.md
ROTARY_POSITION -- requirements
Module: rotary_position

Interface
REQ-001 Parameter WIDTH, 8, position register width in bits.
REQ-002 Parameter POS_MIN, 0, lowest legal position.
REQ-003 Parameter POS_MAX, 255, highest legal position; POS_MIN < POS_MAX < 2**WIDTH.
REQ-004 Parameter WRAP, 0, 1 = modular wrap at bounds, 0 = saturate.
REQ-005 Parameter FAST_GAP, 8, step gap in cycles below which acceleration applies.
REQ-006 Parameter ACCEL_STEP, 3, step size when accelerated; 1 <= ACCEL_STEP <= POS_MAX-POS_MIN.
REQ-007 Parameter RESET_POS, POS_MIN, position after reset; POS_MIN <= RESET_POS <= POS_MAX.
REQ-008 i_clk  input  1  single clock; all logic on rising edge.
REQ-009 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-010 i_cnt  input  1  one-cycle step strobe from the rotary encoder decoder.
REQ-011 i_cnt_cw  input  1  step direction, 1 = clockwise (increment), valid with i_cnt.
REQ-012 i_load  input  1  synchronous load strobe.
REQ-013 i_load_value  input  WIDTH  value to load.
REQ-014 i_ready  input  1  consumer accepts the change event.
REQ-015 o_pos  output  WIDTH  current position, registered.
REQ-016 o_valid  output  1  position-changed event pending.
REQ-017 o_limit  output  1  one-cycle pulse: step blocked or clamped at a bound (saturate mode only).

Function
REQ-018 Steps and loads SHALL update o_pos at the rising edge sampling the strobe (1-cycle latency); no combinational input-to-output path.
REQ-019 Gap counter SHALL count cycles since the last accepted i_cnt, saturating at FAST_GAP; cleared to 0 on each i_cnt.
REQ-020 Step size SHALL be ACCEL_STEP if gap < FAST_GAP and i_cnt_cw equals last direction, else 1.
REQ-021 Last direction SHALL be updated on every i_cnt; a reversal always yields step 1.
REQ-022 Arithmetic SHALL use WIDTH+1 bits internally; no silent overflow of the 2**WIDTH range.
REQ-023 Saturate mode: result clamped to [POS_MIN, POS_MAX]; o_limit pulses if the unclamped result exceeded a bound.
REQ-024 Saturate mode: step at a bound with no movement SHALL NOT set o_valid.
REQ-025 Wrap mode: result SHALL be POS_MIN + ((pos - POS_MIN +/- step) mod (POS_MAX-POS_MIN+1)); o_limit stays 0.
REQ-026 i_load SHALL take priority over a same-cycle i_cnt; the i_cnt is discarded but still updates gap counter and last direction.
REQ-027 Load value SHALL be clamped to [POS_MIN, POS_MAX] in both modes.
REQ-028 o_valid SHALL set on any cycle o_pos changes value; a load of the current value SHALL NOT set it.
REQ-029 o_valid SHALL clear on the edge where o_valid && i_ready, unless o_pos changes that same edge, in which case it stays 1.
REQ-030 o_pos SHALL track all changes while o_valid is pending (events coalesce; consumer reads latest).

Reset
REQ-031 On i_rst_n low, asynchronously: o_pos = RESET_POS, o_valid = 0, o_limit = 0, gap counter = FAST_GAP, last direction = clockwise.
REQ-032 Reset asserted mid-operation SHALL drop any pending event; first step after release is size 1.

Structure
REQ-033 Shared header rotary_defs.vh SHALL hold direction constants (CW = 1, CCW = 0) and mode constants (MODE_SAT, MODE_WRAP), used also by the encoder decoder.
REQ-034 Gap counter and step-size selection SHALL be one sub-module, rotary_accel (inputs i_clk, i_rst_n, i_cnt, i_cnt_cw; output step size).

Verification (WIDTH=4, POS_MIN=0, POS_MAX=9, FAST_GAP=8, ACCEL_STEP=3, RESET_POS=0, i_ready=1 unless noted)
REQ-035 Reset, then three CW strobes 20 cycles apart -> o_pos 1, 2, 3, one o_valid cycle each; o_limit never 1.
REQ-036 CW strobes 4 cycles apart from 0 -> o_pos 1, 4, 7; next strobe CCW 4 cycles later -> o_pos 6.
REQ-037 WRAP=0, o_pos=9, CW strobe -> o_pos 9, o_limit 1 cycle, o_valid 0; from 7 accelerated CW -> o_pos 9, o_limit 1, o_valid 1.
REQ-038 WRAP=1, o_pos=9, slow CW -> 0; slow CCW -> 9; from 8 accelerated CW -> 1.
REQ-039 i_ready=0, two steps -> o_valid held, o_pos latest; i_ready=1 with step same edge -> o_valid stays 1; i_load 5 with i_cnt same cycle -> 5; i_load 12 -> 9.
REQ-040 i_rst_n low mid-burst with o_valid=1 -> immediately o_pos=0, o_valid=0; next strobe after release steps by 1.
